// File: rtl/shift_reg_sipo.sv
// shift_reg_sipo: LSB-first serial-in, parallel-out receive shift register.
// Bits are collected on enabled edges. Every WIDTH bits the assembled word
// moves into a holding register that stays valid until the consumer acks it.
// A word that completes while the holding register is still full is dropped,
// and the drop sets a sticky overrun flag.
//
// Handshake: o_valid=1 means o_data_out holds a word that has not been
// acknowledged. A one-cycle i_ack while o_valid=1 consumes the word. There is
// no ready/backpressure toward the serial side: if a word completes while the
// holding register is full and not being acked on that same edge, the new word
// is lost and o_overrun latches. i_ack while o_valid=0 has no effect.
module shift_reg_sipo #(
  parameter int WIDTH = 4,
  parameter int CNTW  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_enable,
  input  logic             i_din,
  input  logic             i_clear,
  input  logic             i_ack,
  output logic [WIDTH-1:0] o_data_out,
  output logic             o_valid,
  output logic             o_overrun,
  output logic [CNTW-1:0]  o_bit_count
);

  // Counter value on the edge that samples the last bit of a word.
  localparam logic [CNTW-1:0] LAST_CNT = CNTW'(WIDTH - 1);

  // Holding-buffer state; o_valid is this state seen from outside.
  typedef enum logic {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } buf_state_t;

  logic [WIDTH-1:0] r_shreg;
  logic [CNTW-1:0]  r_cnt;
  buf_state_t       r_state;
  logic [WIDTH-1:0] r_data_out;
  logic             r_overrun;

  logic             w_complete;
  logic [WIDTH-1:0] w_word;

  // The incoming bit enters at the top, so the first bit ends up in bit 0.
  assign w_word     = {i_din, r_shreg[WIDTH-1:1]};
  assign w_complete = i_enable && (r_cnt == LAST_CNT);

  // Serial side: shift register and bit counter, both held when not enabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shreg <= '0;
      r_cnt   <= '0;
    end else if (i_clear) begin
      r_shreg <= '0;
      r_cnt   <= '0;
    end else if (i_enable) begin
      r_shreg <= w_word;
      if (r_cnt == LAST_CNT) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // Holding-buffer FSM: takes completed words, consumes acks, tracks overrun.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= BUF_EMPTY;
      r_data_out <= '0;
      r_overrun  <= 1'b0;
    end else if (i_clear) begin
      r_state    <= BUF_EMPTY;
      r_data_out <= '0;
      r_overrun  <= 1'b0;
    end else begin
      case (r_state)
        BUF_EMPTY: begin
          if (w_complete) begin
            r_data_out <= w_word;
            r_state    <= BUF_FULL;
          end
        end
        BUF_FULL: begin
          if (w_complete) begin
            // An ack on the same edge frees the slot for the new word.
            if (i_ack) begin
              r_data_out <= w_word;
            end else begin
              r_overrun <= 1'b1;
            end
          end else if (i_ack) begin
            r_state <= BUF_EMPTY;
          end
        end
        default: begin
          r_state <= BUF_EMPTY;
        end
      endcase
    end
  end

  assign o_data_out  = r_data_out;
  assign o_valid     = (r_state == BUF_FULL);
  assign o_overrun   = r_overrun;
  assign o_bit_count = r_cnt;

endmodule

// File: tb/tb_shift_reg_sipo.sv
// Directed bench for shift_reg_sipo (WIDTH=4): basic word, loopback from a
// transmitter model, gapped enable, overrun, ack on completion, mid-word reset.
module tb_shift_reg_sipo;

  localparam int WIDTH = 4;
  localparam int CNTW  = 3;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // driven inputs
  logic enable = 1'b0;
  logic din_drv = 1'b0;
  logic clear = 1'b0;
  logic ack = 1'b0;
  logic lb_mode = 1'b0;

  logic [WIDTH-1:0] data_out;
  logic             valid;
  logic             overrun;
  logic [CNTW-1:0]  bit_count;

  // Transmitter model: loaded with 4'hA during reset, shifts right LSB-first.
  logic [WIDTH-1:0] tx_reg;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) tx_reg <= 4'hA;
    else if (enable && lb_mode) tx_reg <= {1'b0, tx_reg[WIDTH-1:1]};
  end

  logic din;
  assign din = lb_mode ? tx_reg[0] : din_drv;

  shift_reg_sipo #(.WIDTH(WIDTH), .CNTW(CNTW)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_enable    (enable),
    .i_din       (din),
    .i_clear     (clear),
    .i_ack       (ack),
    .o_data_out  (data_out),
    .o_valid     (valid),
    .o_overrun   (overrun),
    .o_bit_count (bit_count)
  );

  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // One enabled edge with bit b (and optional ack); returns 1 time unit after the edge.
  task automatic send_bit(input logic b, input logic a);
    @(negedge clk);
    enable  = 1'b1;
    din_drv = b;
    ack     = a;
    @(posedge clk);
    #1;
    enable = 1'b0;
    ack    = 1'b0;
  endtask

  // Send a 4-bit word LSB first, no ack.
  task automatic send_word(input logic [WIDTH-1:0] w);
    for (int i = 0; i < WIDTH; i++) send_bit(w[i], 1'b0);
  endtask

  task automatic pulse_ack();
    @(negedge clk);
    ack = 1'b1;
    @(posedge clk);
    #1;
    ack = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [3:0] d, input logic v,
                           input logic o, input logic [2:0] bc);
    check({tag, ".data"}, 32'(data_out), 32'(d));
    check({tag, ".valid"}, 32'(valid), 32'(v));
    check({tag, ".ovr"}, 32'(overrun), 32'(o));
    check({tag, ".bc"}, 32'(bit_count), 32'(bc));
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    check_all("reset", 4'h0, 1'b0, 1'b0, 3'd0);
    rst = 1'b0;

    // Basic word 1,1,0,1 -> 4'b1011
    send_bit(1'b1, 1'b0); check("basic.bc1", 32'(bit_count), 32'd1);
    check("basic.v1", 32'(valid), 32'd0);
    send_bit(1'b1, 1'b0); check("basic.bc2", 32'(bit_count), 32'd2);
    send_bit(1'b0, 1'b0); check("basic.bc3", 32'(bit_count), 32'd3);
    check("basic.v3", 32'(valid), 32'd0);
    send_bit(1'b1, 1'b0);
    check_all("basic.done", 4'b1011, 1'b1, 1'b0, 3'd0);
    pulse_ack();
    check_all("basic.ack", 4'b1011, 1'b0, 1'b0, 3'd0);
    // ack while empty does nothing
    pulse_ack();
    check_all("basic.ack2", 4'b1011, 1'b0, 1'b0, 3'd0);

    // Loopback: transmitter and receiver released from reset together
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst     = 1'b0;
    lb_mode = 1'b1;
    for (int i = 0; i < WIDTH; i++) send_bit(1'b0, 1'b0);
    lb_mode = 1'b0;
    check_all("loop", 4'hA, 1'b1, 1'b0, 3'd0);
    pulse_ack();
    check("loop.ack", 32'(valid), 32'd0);

    // Gapped enable: 0,1,1,1 with 3 idle cycles between -> 4'hE
    send_bit(1'b0, 1'b0); idle(3);
    send_bit(1'b1, 1'b0); idle(3);
    check("gap.bc2", 32'(bit_count), 32'd2);
    send_bit(1'b1, 1'b0); idle(3);
    check("gap.v3", 32'(valid), 32'd0);
    check("gap.bc3", 32'(bit_count), 32'd3);
    send_bit(1'b1, 1'b0);
    check_all("gap.done", 4'hE, 1'b1, 1'b0, 3'd0);
    pulse_ack();

    // Overrun: 3 unread, then 5 is dropped
    send_word(4'h3);
    check_all("ovr.first", 4'h3, 1'b1, 1'b0, 3'd0);
    send_word(4'h5);
    check_all("ovr.drop", 4'h3, 1'b1, 1'b1, 3'd0);
    pulse_ack();
    check_all("ovr.ack", 4'h3, 1'b0, 1'b1, 3'd0);
    // clear wins over enable and ack on the same edge
    @(negedge clk);
    clear = 1'b1; enable = 1'b1; ack = 1'b1; din_drv = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0; enable = 1'b0; ack = 1'b0;
    check_all("ovr.clear", 4'h0, 1'b0, 1'b0, 3'd0);

    // Completion of 9 with ack on the same edge while FULL with 3
    send_word(4'h3);
    check_all("sim.first", 4'h3, 1'b1, 1'b0, 3'd0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b1);
    check_all("sim.done", 4'h9, 1'b1, 1'b0, 3'd0);

    // Mid-word asynchronous reset
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    check("mid.bc2", 32'(bit_count), 32'd2);
    #3 rst = 1'b1;
    #1 check_all("mid.rst", 4'h0, 1'b0, 1'b0, 3'd0);
    #1 rst = 1'b0;
    send_word(4'h4);
    check_all("mid.word", 4'h4, 1'b1, 1'b0, 3'd0);

    // Continuous enable: back-to-back words, ack within the window
    for (int i = 0; i < WIDTH; i++) send_bit(i == 0, i == 0);
    check_all("b2b", 4'h1, 1'b1, 1'b0, 3'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
